// File: rtl/register_file_if.sv
// Bus between the register file and its clients: instruction-unit renames,
// ROB commits and the two source-operand lookup ports.
interface register_file_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 clear;
    logic                 renameValid;
    logic [4:0]           renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;
    logic                 regUpdateValid;
    logic [4:0]           regUpdateDest;
    logic [31:0]          regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;
    logic [4:0]           rs1Addr;
    logic                 rs1Busy;
    logic [ROB_WIDTH-1:0] rs1Dep;
    logic [31:0]          rs1Value;
    logic [4:0]           rs2Addr;
    logic                 rs2Busy;
    logic [ROB_WIDTH-1:0] rs2Dep;
    logic [31:0]          rs2Value;

    modport master (
        output clear, renameValid, renameDest, renameRobId,
        output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output rs1Addr, rs2Addr,
        input  rs1Busy, rs1Dep, rs1Value, rs2Busy, rs2Dep, rs2Value
    );

    modport slave (
        input  clear, renameValid, renameDest, renameRobId,
        input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  rs1Addr, rs2Addr,
        output rs1Busy, rs1Dep, rs1Value, rs2Busy, rs2Dep, rs2Value
    );
endinterface

// File: rtl/register_file.sv
// Architectural RV32I register file with per-register rename tags (ROB index)
// and combinational source lookup with same-cycle commit bypass.
module register_file #(
    parameter int ROB_WIDTH = 4
) (
    input logic            clockIn,
    input logic            resetIn,
    register_file_if.slave bus
);
    localparam int LOOKUP_W = 1 + ROB_WIDTH + 32;

    logic [31:0]          valueArr [1:31];
    logic                 busyArr  [1:31];
    logic [ROB_WIDTH-1:0] tagArr   [1:31];

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : genReg
            logic [31:0]          valueReg;
            logic                 busyReg;
            logic [ROB_WIDTH-1:0] tagReg;
            logic                 commitHit;
            logic                 renameHit;

            assign commitHit = bus.regUpdateValid && (bus.regUpdateDest == 5'(gi));
            assign renameHit = bus.renameValid && (bus.renameDest == 5'(gi));

            // Value always takes the commit; busy/tag priority is clear, then rename,
            // then a commit retiring the newest outstanding rename.
            always_ff @(posedge clockIn or posedge resetIn) begin
                if (resetIn) begin
                    valueReg <= '0;
                    busyReg  <= 1'b0;
                    tagReg   <= '0;
                end else begin
                    if (commitHit) begin
                        valueReg <= bus.regValue;
                    end
                    if (bus.clear) begin
                        busyReg <= 1'b0;
                        tagReg  <= '0;
                    end else if (renameHit) begin
                        busyReg <= 1'b1;
                        tagReg  <= bus.renameRobId;
                    end else if (commitHit && busyReg && (tagReg == bus.regUpdateRobId)) begin
                        busyReg <= 1'b0;
                    end
                end
            end

            assign valueArr[gi] = valueReg;
            assign busyArr[gi]  = busyReg;
            assign tagArr[gi]   = tagReg;
        end
    endgenerate

    // Returns {busy, dep, value}; x0 reads as all zero and never bypasses.
    function automatic logic [LOOKUP_W-1:0] lookup(
        input logic [4:0]           addr,
        input logic                 updValid,
        input logic [4:0]           updDest,
        input logic [ROB_WIDTH-1:0] updRobId,
        input logic [31:0]          updValue
    );
        logic [LOOKUP_W-1:0] result;
        result = '0;
        if (addr != 5'd0) begin
            if (updValid && (updDest == addr) && busyArr[addr] && (tagArr[addr] == updRobId)) begin
                result = {1'b0, tagArr[addr], updValue};
            end else begin
                result = {busyArr[addr], tagArr[addr], valueArr[addr]};
            end
        end
        return result;
    endfunction

    assign {bus.rs1Busy, bus.rs1Dep, bus.rs1Value} =
        lookup(bus.rs1Addr, bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateRobId, bus.regValue);
    assign {bus.rs2Busy, bus.rs2Dep, bus.rs2Value} =
        lookup(bus.rs2Addr, bus.regUpdateValid, bus.regUpdateDest, bus.regUpdateRobId, bus.regValue);
endmodule
